// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA text console writer: FSM states, control codes, fixed addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_console_pkg;

    typedef enum logic [3:0] {
        ST_INIT_MODE,
        ST_CLR_ALL,
        ST_IDLE,
        ST_WR_CHAR,
        ST_SCROLL_RD,
        ST_SCROLL_W1,
        ST_SCROLL_W2,
        ST_SCROLL_WR,
        ST_CLR_ROW,
        ST_ESC_FG,
        ST_ESC_BG
    } state_t;

    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_ESC = 8'h1B;

    localparam int VGA_MODE_INFO_ADDR = 20479;
    localparam int BYTES_PER_CELL     = 3;

endpackage

// File: rtl/vga_console_fill_pattern.sv
// Clear-word generator: cycles {fg,0x20}, {0x20,bg}, {bg,fg} so consecutive words lay down blank cells.
// Latency: pattern is combinational from the phase register; phase advances one step per cycle with step=1.
// Backpressure: none; the caller holds step low to freeze the phase and pulses restart to realign to phase 0.
// Ports: main_clk/main_rst_n clock and sync active-low reset; restart forces phase 0;
//        step advances the phase; fg/bg current colours; pattern 16-bit word to write.
module vga_console_fill_pattern (
    input  logic        main_clk,
    input  logic        main_rst_n,
    input  logic        restart,
    input  logic        step,
    input  logic [7:0]  fg,
    input  logic [7:0]  bg,
    output logic [15:0] pattern
);

    logic [1:0] phase;

    always_ff @(posedge main_clk) begin
        if (!main_rst_n || restart) begin
            phase <= 2'd0;
        end else if (step) begin
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end
    end

    // Little-endian words: low byte lands at the even address.
    always_comb begin
        case (phase)
            2'd0:    pattern = {fg, 8'h20};
            2'd1:    pattern = {8'h20, bg};
            default: pattern = {bg, fg};
        endcase
    end

endmodule

// File: rtl/vga_text_console_writer.sv
// Text console front end: turns a character/control byte stream into VGA memory io writes (cursor, wrap, scroll, clear).
// Latency: io_* and status outputs are registered, one cycle behind the FSM; printable char = 3 byte writes.
// Backpressure: ch_ready is high only when the next byte can be taken; bytes are never dropped.
// Ports: main_clk, main_rst_n (sync, active-low); ch_valid/ch_data/ch_ready character input;
//        busy during init/scroll/clear; io_do_write, io_do_byte_op, io_addr, io_write_data, io_read_data memory port.
// Build option: define VGA_CONSOLE_ESC_COLOR_EN to make 0x1B,fg,bg set the colours instead of printing 0x1B.
module vga_text_console_writer
    import vga_console_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] MODE_INFO  = 8'h1D,
    parameter logic [7:0] DEFAULT_FG = 8'hFF,
    parameter logic [7:0] DEFAULT_BG = 8'h00
) (
    input  logic        main_clk,
    input  logic        main_rst_n,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    output logic        busy,
    output logic        io_do_write,
    output logic        io_do_byte_op,
    output logic [14:0] io_addr,
    output logic [15:0] io_write_data,
    input  logic [15:0] io_read_data
);

    // Clears and scrolls move whole words, so a row must be an even number of bytes.
    if ((BYTES_PER_CELL * COLS) % 2 != 0) begin : g_row_bytes_check
        $error("BYTES_PER_CELL*COLS must be even");
    end

    localparam logic [7:0]  COL_LAST       = 8'(COLS - 1);
    localparam logic [7:0]  ROW_LAST       = 8'(ROWS - 1);
    localparam logic [14:0] ROW_BYTES      = 15'(BYTES_PER_CELL * COLS);
    localparam logic [14:0] LAST_ROW_BASE  = 15'(BYTES_PER_CELL * COLS * (ROWS - 1));
    localparam logic [14:0] ADDR_LAST_WORD = 15'(BYTES_PER_CELL * COLS * ROWS - 2);
    localparam logic [14:0] MODE_ADDR      = 15'(VGA_MODE_INFO_ADDR);

    state_t      state, state_n;
    logic [7:0]  row, row_n, col, col_n;
    logic [14:0] ptr, ptr_n;
    logic [1:0]  bphase, bphase_n;
    logic [7:0]  char_q, char_n;
    logic        bs_q, bs_n;
    logic [7:0]  fg, fg_n, bg, bg_n;
    logic        wr_n, byte_n;
    logic [14:0] addr_n;
    logic [15:0] wdata_n;
    logic [7:0]  cell_byte;
    logic [14:0] cell_base;
    logic [15:0] fill_word;
    logic        fill_active;
    logic        accept;

    assign accept      = ch_valid && ch_ready;
    assign cell_base   = 15'(BYTES_PER_CELL * (int'(row) * COLS + int'(col)));
    assign fill_active = (state == ST_CLR_ALL) || (state == ST_CLR_ROW);

    // Phase is held at 0 outside a fill, so every fill starts on a cell boundary.
    vga_console_fill_pattern u_fill (
        .main_clk   (main_clk),
        .main_rst_n (main_rst_n),
        .restart    (!fill_active),
        .step       (fill_active),
        .fg         (fg),
        .bg         (bg),
        .pattern    (fill_word)
    );

    always_ff @(posedge main_clk) begin
        if (!main_rst_n) begin
            state         <= ST_INIT_MODE;
            row           <= '0;
            col           <= '0;
            ptr           <= '0;
            bphase        <= '0;
            char_q        <= '0;
            bs_q          <= 1'b0;
            fg            <= DEFAULT_FG;
            bg            <= DEFAULT_BG;
            ch_ready      <= 1'b0;
            busy          <= 1'b0;
            io_do_write   <= 1'b0;
            io_do_byte_op <= 1'b0;
            io_addr       <= '0;
            io_write_data <= '0;
        end else begin
            state         <= state_n;
            row           <= row_n;
            col           <= col_n;
            ptr           <= ptr_n;
            bphase        <= bphase_n;
            char_q        <= char_n;
            bs_q          <= bs_n;
            fg            <= fg_n;
            bg            <= bg_n;
            // Status is derived from the next state so it always matches the state register.
            ch_ready      <= (state_n == ST_IDLE) || (state_n == ST_ESC_FG) || (state_n == ST_ESC_BG);
            busy          <= (state_n == ST_INIT_MODE) || (state_n == ST_CLR_ALL) || (state_n == ST_CLR_ROW) ||
                             (state_n == ST_SCROLL_RD) || (state_n == ST_SCROLL_W1) ||
                             (state_n == ST_SCROLL_W2) || (state_n == ST_SCROLL_WR);
            io_do_write   <= wr_n;
            io_do_byte_op <= byte_n;
            io_addr       <= addr_n;
            io_write_data <= wdata_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col;
        ptr_n     = ptr;
        bphase_n  = bphase;
        char_n    = char_q;
        bs_n      = bs_q;
        fg_n      = fg;
        bg_n      = bg;
        wr_n      = 1'b0;
        byte_n    = 1'b0;
        addr_n    = '0;
        wdata_n   = '0;
        cell_byte = char_q;

        case (state)
            ST_INIT_MODE: begin
                wr_n    = 1'b1;
                byte_n  = 1'b1;
                addr_n  = MODE_ADDR;
                wdata_n = {MODE_INFO, MODE_INFO};
                ptr_n   = '0;
                state_n = ST_CLR_ALL;
            end

            ST_CLR_ALL, ST_CLR_ROW: begin
                wr_n    = 1'b1;
                addr_n  = ptr;
                wdata_n = fill_word;
                ptr_n   = ptr + 15'd2;
                if (ptr == ADDR_LAST_WORD) begin
                    state_n = ST_IDLE;
                    if (state == ST_CLR_ALL) begin
                        row_n = '0;
                        col_n = '0;
                    end
                end
            end

            ST_IDLE: begin
                if (accept) begin
                    case (ch_data)
                        CC_LF: begin
                            col_n = '0;
                            if (row == ROW_LAST) begin
                                ptr_n   = ROW_BYTES;
                                state_n = ST_SCROLL_RD;
                            end else begin
                                row_n = row + 8'd1;
                            end
                        end
                        CC_CR: col_n = '0;
                        CC_BS: begin
                            // No reverse wrap: backspace at column 0 is ignored.
                            if (col != 8'd0) begin
                                col_n    = col - 8'd1;
                                char_n   = 8'h20;
                                bs_n     = 1'b1;
                                bphase_n = '0;
                                state_n  = ST_WR_CHAR;
                            end
                        end
                        CC_FF: begin
                            ptr_n   = '0;
                            state_n = ST_CLR_ALL;
                        end
`ifdef VGA_CONSOLE_ESC_COLOR_EN
                        CC_ESC: state_n = ST_ESC_FG;
`endif
                        default: begin
                            char_n   = ch_data;
                            bs_n     = 1'b0;
                            bphase_n = '0;
                            state_n  = ST_WR_CHAR;
                        end
                    endcase
                end
            end

            ST_WR_CHAR: begin
                case (bphase)
                    2'd0:    cell_byte = char_q;
                    2'd1:    cell_byte = fg;
                    default: cell_byte = bg;
                endcase
                wr_n     = 1'b1;
                byte_n   = 1'b1;
                addr_n   = cell_base + 15'(bphase);
                wdata_n  = {cell_byte, cell_byte};
                bphase_n = bphase + 2'd1;
                if (bphase == 2'd2) begin
                    bphase_n = '0;
                    state_n  = ST_IDLE;
                    // A backspace blank leaves the cursor on the blanked cell.
                    if (!bs_q) begin
                        if (col == COL_LAST) begin
                            col_n = '0;
                            if (row == ROW_LAST) begin
                                ptr_n   = ROW_BYTES;
                                state_n = ST_SCROLL_RD;
                            end else begin
                                row_n = row + 8'd1;
                            end
                        end else begin
                            col_n = col + 8'd1;
                        end
                    end
                end
            end

            // Outputs are registered, so the read is on the bus one cycle after SCROLL_RD and
            // io_read_data is valid while the FSM sits in SCROLL_WR.
            ST_SCROLL_RD: begin
                addr_n  = ptr;
                state_n = ST_SCROLL_W1;
            end
            ST_SCROLL_W1: begin
                addr_n  = ptr;
                state_n = ST_SCROLL_W2;
            end
            ST_SCROLL_W2: begin
                addr_n  = ptr;
                state_n = ST_SCROLL_WR;
            end
            ST_SCROLL_WR: begin
                wr_n    = 1'b1;
                addr_n  = ptr - ROW_BYTES;
                wdata_n = io_read_data;
                if (ptr == ADDR_LAST_WORD) begin
                    ptr_n   = LAST_ROW_BASE;
                    state_n = ST_CLR_ROW;
                end else begin
                    ptr_n   = ptr + 15'd2;
                    state_n = ST_SCROLL_RD;
                end
            end

`ifdef VGA_CONSOLE_ESC_COLOR_EN
            ST_ESC_FG: begin
                if (accept) begin
                    fg_n    = ch_data;
                    state_n = ST_ESC_BG;
                end
            end
            ST_ESC_BG: begin
                if (accept) begin
                    bg_n    = ch_data;
                    state_n = ST_IDLE;
                end
            end
`endif

            default: state_n = ST_IDLE;
        endcase
    end

endmodule
